// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - AXI4-Lite shared types, response codes and helpers.
package axi4l_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic is_err(input resp_t resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/axi4l_if.sv
// rtl/axi4l_if.sv - AXI4-Lite five-channel bus with master and slave views.
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t      awaddr;
  logic [2:0] awprot;
  logic       awvalid;
  logic       awready;
  data_t      wdata;
  strb_t      wstrb;
  logic       wvalid;
  logic       wready;
  resp_t      bresp;
  logic       bvalid;
  logic       bready;
  addr_t      araddr;
  logic [2:0] arprot;
  logic       arvalid;
  logic       arready;
  data_t      rdata;
  resp_t      rresp;
  logic       rvalid;
  logic       rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );
  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/core_if.sv
// rtl/core_if.sv - Ibex-style core memory port (req/gnt request, rvalid response).
interface core_if;
  import axi4l_pkg::*;

  logic  req;
  logic  we;
  strb_t be;
  addr_t addr;
  data_t wdata;
  logic  gnt;
  logic  rvalid;
  data_t rdata;
  logic  err;

  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
endinterface

// File: rtl/core2axi4l.sv
// rtl/core2axi4l.sv - Core memory port to AXI4-Lite master bridge, one transaction in flight.
// Optional response timeout with drain: CORE2AXI4L_TIMEOUT_EN.
module core2axi4l
  import axi4l_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic     aclk,
  input logic     aresetn,
  core_if.slave   core,
  axi4l_if.master axi
);

`ifdef CORE2AXI4L_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, WRITE_ADDR, READ_ADDR, WRITE_RESP, READ_RESP, DRAIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE_ADDR, READ_ADDR, WRITE_RESP, READ_RESP} state_t;
`endif

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t r_state;
  addr_t  r_addr;
  data_t  r_wdata;
  strb_t  r_be;
  logic   r_we;
  logic   r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic   r_aw_done, r_w_done;
  logic   r_rvalid, r_err;
  data_t  r_rdata;

  logic w_gnt, w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs, w_aw_all, w_w_all;

  assign w_gnt    = aresetn && (r_state == IDLE);
  assign w_aw_hs  = r_awvalid && axi.awready;
  assign w_w_hs   = r_wvalid && axi.wready;
  assign w_ar_hs  = r_arvalid && axi.arready;
  assign w_b_hs   = r_bready && axi.bvalid;
  assign w_r_hs   = r_rready && axi.rvalid;
  assign w_aw_all = r_aw_done || w_aw_hs;
  assign w_w_all  = r_w_done || w_w_hs;

`ifdef CORE2AXI4L_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  // Fires one edge early so the error pulse lands TIMEOUT_CYCLES after the grant.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             w_busy, w_timeout;

  assign w_busy    = r_state inside {WRITE_ADDR, READ_ADDR, WRITE_RESP, READ_RESP};
  assign w_timeout = w_busy && (r_cnt == CNT_FIRE) && !w_b_hs && !w_r_hs;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_we      <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_bready  <= 1'b0;
      r_rready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
`ifdef CORE2AXI4L_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (core.req) begin
            r_addr    <= core.addr;
            r_wdata   <= core.wdata;
            r_be      <= core.be;
            r_we      <= core.we;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (core.we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WRITE_ADDR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= READ_ADDR;
            end
          end
        end
        WRITE_ADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_all && w_w_all) begin
            r_bready <= 1'b1;
            r_state  <= WRITE_RESP;
          end
        end
        READ_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= READ_RESP;
          end
        end
        WRITE_RESP: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= is_err(axi.bresp);
            r_rdata  <= '0;
            r_state  <= IDLE;
          end
        end
        READ_RESP: begin
          if (w_r_hs) begin
            r_rready <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= is_err(axi.rresp);
            r_rdata  <= axi.rdata;
            r_state  <= IDLE;
          end
        end
`ifdef CORE2AXI4L_TIMEOUT_EN
        DRAIN: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
          if (r_we && w_aw_all && w_w_all && !r_bready) r_bready <= 1'b1;
          // The late response is swallowed; the core already got its error.
          if (w_b_hs || w_r_hs) begin
            r_bready <= 1'b0;
            r_rready <= 1'b0;
            r_state  <= IDLE;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
`ifdef CORE2AXI4L_TIMEOUT_EN
      if (w_gnt && core.req) r_cnt <= '0;
      else if (w_busy)       r_cnt <= r_cnt + 1'b1;
      if (w_timeout) begin
        r_rvalid <= 1'b1;
        r_err    <= 1'b1;
        r_rdata  <= '0;
        r_state  <= DRAIN;
      end
`endif
    end
  end

  assign core.gnt    = w_gnt;
  assign core.rvalid = r_rvalid;
  assign core.rdata  = r_rdata;
  assign core.err    = r_err;

  assign axi.awaddr  = r_addr;
  assign axi.awprot  = PROT_DEFAULT;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_be;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;
  assign axi.araddr  = r_addr;
  assign axi.arprot  = PROT_DEFAULT;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;

endmodule

// File: tb/tb_core2axi4l.sv
// tb/tb_core2axi4l.sv - Directed vector bench for core2axi4l with a latency-programmable AXI slave.
module tb_core2axi4l;
  import axi4l_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_if  u_core ();
  axi4l_if u_axi (.aclk(clk), .aresetn(rst_n));

`ifdef CORE2AXI4L_TIMEOUT_EN
  core2axi4l #(.TIMEOUT_CYCLES(8)) u_dut (.aclk(clk), .aresetn(rst_n), .core(u_core.slave), .axi(u_axi.master));
`else
  core2axi4l u_dut (.aclk(clk), .aresetn(rst_n), .core(u_core.slave), .axi(u_axi.master));
`endif

  typedef struct {
    logic  we;
    addr_t addr;
    data_t wdata;
    strb_t be;
    int    aw_lat, w_lat, ar_lat, b_lat, r_lat;
    resp_t resp;
    data_t rdata;
    int    exp_lat;
    logic  exp_err;
    data_t exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int proto_err = 0;

  int    aw_lat, w_lat, ar_lat, b_lat, r_lat;
  resp_t sl_resp;
  data_t sl_rdata;
  addr_t exp_addr;
  data_t exp_wdata;
  strb_t exp_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // AXI slave: each ready rises after its valid has been seen for *_lat cycles,
  // responses follow the address/data handshakes after b_lat/r_lat cycles.
  initial begin : slave
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_ok, w_ok, ar_ok, hs_aw, hs_w, hs_ar, hs_b, hs_r;
    logic p_awv, p_wv, p_arv;
    addr_t p_awaddr, p_araddr;
    data_t p_wdata;
    strb_t p_wstrb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        u_axi.awready = 1'b0; u_axi.wready = 1'b0; u_axi.arready = 1'b0;
        u_axi.bvalid = 1'b0; u_axi.bresp = OKAY;
        u_axi.rvalid = 1'b0; u_axi.rresp = OKAY; u_axi.rdata = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_ok = 0; w_ok = 0; ar_ok = 0;
        hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
      end else begin
        if (p_awv && !hs_aw && (!u_axi.awvalid || u_axi.awaddr !== p_awaddr)) proto_err++;
        if (p_wv && !hs_w && (!u_axi.wvalid || u_axi.wdata !== p_wdata || u_axi.wstrb !== p_wstrb)) proto_err++;
        if (p_arv && !hs_ar && (!u_axi.arvalid || u_axi.araddr !== p_araddr)) proto_err++;
        if (hs_aw) begin u_axi.awready = 1'b0; aw_ok = 1; aw_cnt = 0; end
        if (hs_w)  begin u_axi.wready = 1'b0;  w_ok = 1;  w_cnt = 0;  end
        if (hs_ar) begin u_axi.arready = 1'b0; ar_ok = 1; ar_cnt = 0; end
        if (hs_b) u_axi.bvalid = 1'b0;
        if (hs_r) u_axi.rvalid = 1'b0;
        if (u_axi.awvalid && !u_axi.awready) begin
          if (aw_cnt == aw_lat) u_axi.awready = 1'b1; else aw_cnt++;
        end
        if (u_axi.wvalid && !u_axi.wready) begin
          if (w_cnt == w_lat) u_axi.wready = 1'b1; else w_cnt++;
        end
        if (u_axi.arvalid && !u_axi.arready) begin
          if (ar_cnt == ar_lat) u_axi.arready = 1'b1; else ar_cnt++;
        end
        if (aw_ok && w_ok && !u_axi.bvalid) begin
          if (b_cnt == b_lat) begin
            u_axi.bvalid = 1'b1; u_axi.bresp = sl_resp; aw_ok = 0; w_ok = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (ar_ok && !u_axi.rvalid) begin
          if (r_cnt == r_lat) begin
            u_axi.rvalid = 1'b1; u_axi.rresp = sl_resp; u_axi.rdata = sl_rdata; ar_ok = 0; r_cnt = 0;
          end else r_cnt++;
        end
        hs_aw = u_axi.awvalid && u_axi.awready;
        hs_w  = u_axi.wvalid && u_axi.wready;
        hs_ar = u_axi.arvalid && u_axi.arready;
        hs_b  = u_axi.bvalid && u_axi.bready;
        hs_r  = u_axi.rvalid && u_axi.rready;
        if (hs_aw) begin
          chk("awaddr", u_axi.awaddr, exp_addr);
          chk("awprot", {29'd0, u_axi.awprot}, 32'd0);
        end
        if (hs_w) begin
          chk("wdata", u_axi.wdata, exp_wdata);
          chk("wstrb", {28'd0, u_axi.wstrb}, {28'd0, exp_be});
        end
        if (hs_ar) begin
          chk("araddr", u_axi.araddr, exp_addr);
          chk("arprot", {29'd0, u_axi.arprot}, 32'd0);
        end
        p_awv = u_axi.awvalid; p_awaddr = u_axi.awaddr;
        p_wv = u_axi.wvalid; p_wdata = u_axi.wdata; p_wstrb = u_axi.wstrb;
        p_arv = u_axi.arvalid; p_araddr = u_axi.araddr;
      end
    end
  end

  // Called at a negedge with the bridge idle; returns at the negedge after the response pulse.
  task automatic run_txn(input vec_t v, input string tag);
    int c;
    logic got;
    aw_lat = v.aw_lat; w_lat = v.w_lat; ar_lat = v.ar_lat; b_lat = v.b_lat; r_lat = v.r_lat;
    sl_resp = v.resp; sl_rdata = v.rdata;
    exp_addr = v.addr; exp_wdata = v.wdata; exp_be = v.be;
    u_core.req = 1'b1; u_core.we = v.we; u_core.addr = v.addr; u_core.wdata = v.wdata; u_core.be = v.be;
    #1;
    chk({tag, "_gnt"}, {31'd0, u_core.gnt}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    u_core.req = 1'b0;
    got = 1'b0;
    c = 1;
    while (!got && c <= 40) begin
      if (u_core.rvalid) got = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk({tag, "_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({tag, "_lat"}, c, v.exp_lat);
      chk({tag, "_rdata"}, u_core.rdata, v.exp_rdata);
      chk({tag, "_err"}, {31'd0, u_core.err}, {31'd0, v.exp_err});
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, u_core.rvalid}, 32'd0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [5:0] p_ar, p_rr, p_rv;
    int seen;

    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 0, 0, 0, 0, OKAY,   32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 0, 3, 0, 0, 0, OKAY, 32'h0, 6, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_1004, 32'h0, 4'hF, 0, 0, 0, 0, 0, SLVERR, 32'hCAFE_0000, 3, 1'b1, 32'hCAFE_0000};
    vecs[3] = '{1'b1, 32'h0000_2004, 32'h0BAD_F00D, 4'b1111, 0, 0, 0, 0, 0, DECERR, 32'h0, 3, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_1008, 32'h0, 4'hF, 0, 0, 2, 0, 1, OKAY,   32'h0000_00FF, 6, 1'b0, 32'h0000_00FF};
    vecs[5] = '{1'b1, 32'h0000_200C, 32'h5555_AAAA, 4'b1100, 2, 0, 0, 2, 0, OKAY, 32'h0, 7, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_2010, 32'hFFFF_FFFF, 4'b0001, 0, 0, 0, 0, 0, OKAY, 32'h0, 3, 1'b0, 32'h0};

    u_core.req = 1'b0; u_core.we = 1'b0; u_core.addr = '0; u_core.wdata = '0; u_core.be = '0;
    aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0;
    sl_resp = OKAY; sl_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_be = '0;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_axi_ctrl", {27'd0, u_axi.arvalid, u_axi.awvalid, u_axi.wvalid, u_axi.bready, u_axi.rready}, 32'd0);
    chk("rst_rvalid", {31'd0, u_core.rvalid}, 32'd0);
    chk("rst_err", {31'd0, u_core.err}, 32'd0);
    chk("rst_rdata", u_core.rdata, 32'd0);
    chk("rst_gnt", {31'd0, u_core.gnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_gnt", {31'd0, u_core.gnt}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Back-to-back reads with req held: second grant coincides with first rvalid.
    ar_lat = 0; r_lat = 0; sl_resp = OKAY; sl_rdata = 32'hA5A5_0001; exp_addr = 32'h0000_3000;
    p_ar = 6'b001001; p_rr = 6'b010010; p_rv = 6'b100100;
    u_core.req = 1'b1; u_core.we = 1'b0; u_core.addr = 32'h0000_3000;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_arvalid_c%0d", c), {31'd0, u_axi.arvalid}, {31'd0, p_ar[c-1]});
      chk($sformatf("b2b_rready_c%0d", c), {31'd0, u_axi.rready}, {31'd0, p_rr[c-1]});
      chk($sformatf("b2b_rvalid_c%0d", c), {31'd0, u_core.rvalid}, {31'd0, p_rv[c-1]});
      chk($sformatf("b2b_gnt_c%0d", c), {31'd0, u_core.gnt}, {31'd0, p_rv[c-1]});
      if (p_rv[c-1]) chk($sformatf("b2b_rdata_c%0d", c), u_core.rdata, 32'hA5A5_0001);
      if (c == 4) u_core.req = 1'b0;
    end

    // Reset while waiting in READ_RESP: everything drops, no response ever reaches the core.
    ar_lat = 0; r_lat = 5; sl_rdata = 32'h7777_7777; exp_addr = 32'h0000_4000;
    u_core.req = 1'b1; u_core.we = 1'b0; u_core.addr = 32'h0000_4000;
    @(posedge clk);
    @(negedge clk);
    u_core.req = 1'b0;
    @(negedge clk);
    chk("mid_rst_pre_rready", {31'd0, u_axi.rready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_arvalid", {31'd0, u_axi.arvalid}, 32'd0);
    chk("mid_rst_rready", {31'd0, u_axi.rready}, 32'd0);
    chk("mid_rst_rvalid", {31'd0, u_core.rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (u_core.rvalid) seen++;
    end
    chk("mid_rst_no_resp", seen, 0);
    run_txn(vecs[0], "post_rst");

`ifdef CORE2AXI4L_TIMEOUT_EN
    // Slave sits on AR for 20 cycles: error at cycle 8, gnt held low until the late R drains.
    ar_lat = 19; r_lat = 0; sl_resp = OKAY; sl_rdata = 32'h1111_2222; exp_addr = 32'h0000_5000;
    u_core.req = 1'b1; u_core.we = 1'b0; u_core.addr = 32'h0000_5000;
    @(posedge clk);
    @(negedge clk);
    u_core.req = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      chk($sformatf("to_rvalid_c%0d", c), {31'd0, u_core.rvalid}, {31'd0, (c == 8)});
      chk($sformatf("to_gnt_c%0d", c), {31'd0, u_core.gnt}, {31'd0, (c == 22)});
      if (c == 8) begin
        chk("to_err", {31'd0, u_core.err}, 32'd1);
        chk("to_rdata", u_core.rdata, 32'd0);
      end
      if (c < 22) @(negedge clk);
    end
    run_txn(vecs[0], "post_to");
`endif

    @(negedge clk);
    chk("axi_stability", proto_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
